// File: rtl/spi_slave_fifo.sv
// SPI slave on the system clock: synchronised SCLK/CS/MOSI, all four modes,
// full duplex, with show-ahead RX and TX FIFOs.

module spi_slave_fifo_buf #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // a pop frees the slot, so a push on a full FIFO is accepted alongside it
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

module spi_slave_fifo #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       RX_DEPTH    = 16,
  parameter int unsigned       TX_DEPTH    = 16,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_FILL     = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_clk,
  input  logic                      spi_cs,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      busy,
  output logic                      rx_overflow,
  output logic                      tx_underrun
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, PUSH} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, mosi_s;
  logic lead_e, trail_e, sample_e, shift_e;
  logic cs_fall, cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign lead_e   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trail_e  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign sample_e = CPHA ? trail_e : lead_e;
  assign shift_e  = CPHA ? lead_e : trail_e;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;

  state_t              state_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [DATA_W-1:0]   rx_shift_q;
  logic [DATA_W-1:0]   tx_shift_q;
  logic                miso_q;
  logic                oe_q;
  logic                ovf_q;
  logic                unr_q;
  logic                idle_after_q;

  logic                rx_push, rx_empty, rx_full;
  logic                tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0]   tx_head;
  logic [DATA_W-1:0]   load_word_d;
  logic [$clog2(TX_DEPTH):0] tx_count;

  assign rx_push     = (state_q == PUSH);
  assign tx_pop      = (state_q == LOAD) && !cs_rise;
  assign load_word_d = tx_empty ? TX_FILL : tx_head;

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst),
    .push_i(rx_push), .din_i(rx_shift_q),
    .pop_i(rx_ready), .dout_o(rx_data),
    .empty_o(rx_empty), .full_o(rx_full),
    .count_o(rx_count)
  );

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst),
    .push_i(tx_valid), .din_i(tx_data),
    .pop_i(tx_pop), .dout_o(tx_head),
    .empty_o(tx_empty), .full_o(tx_full),
    .count_o(tx_count)
  );

  // shift edges are ignored until the first sample of a word: LOAD already
  // drives the MSB, and for CPHA=0 the trailing edge after the final sample
  // of the previous word must not disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      ovf_q        <= 1'b0;
      unr_q        <= 1'b0;
      idle_after_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          bit_cnt_q    <= '0;
          oe_q         <= 1'b0;
          miso_q       <= 1'b0;
          idle_after_q <= 1'b0;
          if (cs_fall) state_q <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tx_shift_q <= load_word_d;
            miso_q     <= load_word_d[DATA_W-1];
            oe_q       <= 1'b1;
            unr_q      <= tx_empty;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (sample_e && bit_cnt_q == LAST) begin
            rx_shift_q   <= {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_q    <= bit_cnt_q + 1'b1;
            idle_after_q <= cs_rise;
            state_q      <= PUSH;
          end else if (cs_rise) begin
            bit_cnt_q <= '0;
            oe_q      <= 1'b0;
            miso_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            if (sample_e) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
            end
            if (shift_e && bit_cnt_q != '0) begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_W-2];
            end
          end
        end
        PUSH: begin
          bit_cnt_q    <= '0;
          ovf_q        <= rx_full & ~rx_ready;
          idle_after_q <= 1'b0;
          if (idle_after_q || cs_s) begin
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q & ~cs_s;
  assign rx_valid    = ~rx_empty;
  assign tx_ready    = ~tx_full;
  assign busy        = ~cs_s;
  assign rx_overflow = ovf_q;
  assign tx_underrun = unr_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: four instances, one per SPI mode, driven by a
// bit-level SPI master model with queued expected RX/MISO words.

module tb_spi_slave_fifo;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] cs = 4'hF;
  logic [3:0] mosi = 4'h0;
  logic [3:0] rx_ready = 4'h0;
  logic [3:0] tx_valid = 4'h0;
  logic [7:0] tx_data [4];
  logic [3:0] miso, oe, rx_valid, tx_ready, busy, ovf, unr;
  logic [7:0] rx_data [4];
  logic [4:0] rx_count [4];
  logic [2:0] rx_count0;

  int checks = 0;
  int errors = 0;
  int ovf_cnt [4];
  int unr_cnt [4];
  int unstable = 0;
  logic [7:0] mtx [8];
  logic [7:0] mrx [8];
  logic [7:0] got_rx [8];
  logic [7:0] exp_rx [$];
  logic [7:0] exp_miso [$];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

  assign rx_count[0] = {2'b00, rx_count0};

  spi_slave_fifo #(
    .DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(16),
    .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .TX_FILL(8'hEE)
  ) u0 (
    .clk(clk), .rst(rst),
    .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_count(rx_count0), .busy(busy[0]),
    .rx_overflow(ovf[0]), .tx_underrun(unr[0])
  );

  for (genvar g = 1; g < 4; g++) begin : g_dut
    spi_slave_fifo #(
      .DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16),
      .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .SYNC_STAGES(2), .TX_FILL(8'h00)
    ) u (
      .clk(clk), .rst(rst),
      .spi_clk(sclk[g]), .spi_cs(cs[g]), .spi_mosi(mosi[g]),
      .spi_miso(miso[g]), .spi_miso_oe(oe[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_count(rx_count[g]), .busy(busy[g]),
      .rx_overflow(ovf[g]), .tx_underrun(unr[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ovf[i] === 1'b1) ovf_cnt[i]++;
      if (unr[i] === 1'b1) unr_cnt[i]++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] status(input int m);
    return {miso[m], oe[m], rx_valid[m], tx_ready[m], busy[m],
            ovf[m], unr[m], rx_count[m]};
  endfunction

  task automatic tx_push(input int m, input logic [7:0] d);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    wait_clk(1);
    tx_valid[m] = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      ovf_cnt[i] = 0;
      unr_cnt[i] = 0;
    end
    unstable = 0;
  endtask

  // master: n words from mtx, MISO words into mrx; cut>0 stops after that
  // many bits, raising CS on that sample edge only if raise is set
  task automatic spi_frame(input int m, input int n, input int cut,
                           input bit raise);
    logic cpol, cpha, endcs, a, b;
    logic [7:0] w, r;
    int bits;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    bits = 0;
    cs[m] = 1'b0;
    wait_clk(H);
    for (int k = 0; k < n; k++) begin
      w = mtx[k];
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        bits++;
        endcs = (k == n - 1 && i == 0) || (cut > 0 && bits == cut && raise);
        if (!cpha) begin
          mosi[m] = w[i];
          wait_clk(H - 2);
          a = miso[m];
          wait_clk(2);
          b = miso[m];
          if (a !== b || oe[m] !== 1'b1) unstable++;
          r = {r[6:0], b};
          sclk[m] = ~cpol;
          if (endcs) cs[m] = 1'b1;
          wait_clk(H);
          sclk[m] = cpol;
        end else begin
          wait_clk(H);
          sclk[m] = ~cpol;
          mosi[m] = w[i];
          wait_clk(H - 2);
          a = miso[m];
          wait_clk(2);
          b = miso[m];
          if (a !== b || oe[m] !== 1'b1) unstable++;
          r = {r[6:0], b};
          sclk[m] = cpol;
          if (endcs) cs[m] = 1'b1;
        end
        if (cut > 0 && bits == cut) begin
          wait_clk(2 * H);
          return;
        end
      end
      mrx[k] = r;
    end
    wait_clk(2 * H);
  endtask

  task automatic drain(input int m, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (rx_valid[m] !== 1'b1 && t < 200) begin
        wait_clk(1);
        t++;
      end
      if (rx_valid[m] !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout u%0d word %0d: rx_valid=%b required 1",
                 m, i, rx_valid[m]);
        return;
      end
      got_rx[i] = rx_data[m];
      rx_ready[m] = 1'b1;
      wait_clk(1);
      rx_ready[m] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (status(m) !== 12'h100) begin
        errors++;
        $display("FAIL reset_state u%0d: got %h required 100", m, status(m));
      end
    end
  endtask

  task automatic test_mode0();
    logic [7:0] e;
    clear_counts();
    tx_push(0, 8'h81);
    tx_push(0, 8'h7E);
    mtx[0] = 8'hA5;
    mtx[1] = 8'h3C;
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    exp_miso.push_back(8'h81);
    exp_miso.push_back(8'h7E);
    spi_frame(0, 2, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      e = exp_miso.pop_front();
      checks++;
      if (mrx[k] !== e) begin
        errors++;
        $display("FAIL mode0_miso[%0d]: got %h required %h", k, mrx[k], e);
      end
    end
    drain(0, 2);
    for (int k = 0; k < 2; k++) begin
      e = exp_rx.pop_front();
      checks++;
      if (got_rx[k] !== e) begin
        errors++;
        $display("FAIL mode0_rx[%0d]: got %h required %h", k, got_rx[k], e);
      end
    end
    checks++;
    if (ovf_cnt[0] != 0 || unr_cnt[0] != 0 || unstable != 0) begin
      errors++;
      $display("FAIL mode0_pulses: ovf=%0d unr=%0d unstable=%0d required 0",
               ovf_cnt[0], unr_cnt[0], unstable);
    end
  endtask

  task automatic test_modes();
    logic [7:0] e;
    for (int m = 1; m < 4; m++) begin
      clear_counts();
      tx_push(m, 8'hC3);
      mtx[0] = 8'hC3;
      exp_rx.push_back(8'hC3);
      exp_miso.push_back(8'hC3);
      spi_frame(m, 1, 0, 1'b0);
      e = exp_miso.pop_front();
      checks++;
      if (mrx[0] !== e || unstable != 0) begin
        errors++;
        $display("FAIL mode%0d_miso: got %h unstable=%0d required %h",
                 m, mrx[0], unstable, e);
      end
      drain(m, 1);
      e = exp_rx.pop_front();
      checks++;
      if (got_rx[0] !== e) begin
        errors++;
        $display("FAIL mode%0d_rx: got %h required %h", m, got_rx[0], e);
      end
    end
  endtask

  task automatic test_partial();
    logic [7:0] e;
    clear_counts();
    mtx[0] = 8'hFF;
    spi_frame(1, 1, 5, 1'b1);
    checks++;
    if (rx_valid[1] !== 1'b0 || rx_count[1] !== 5'd0) begin
      errors++;
      $display("FAIL partial_dropped: rx_valid=%b count=%0d required 0 0",
               rx_valid[1], rx_count[1]);
    end
    mtx[0] = 8'h12;
    exp_rx.push_back(8'h12);
    spi_frame(1, 1, 0, 1'b0);
    checks++;
    if (rx_count[1] !== 5'd1 || ovf_cnt[1] != 0) begin
      errors++;
      $display("FAIL partial_count: count=%0d ovf=%0d required 1 0",
               rx_count[1], ovf_cnt[1]);
    end
    drain(1, 1);
    e = exp_rx.pop_front();
    checks++;
    if (got_rx[0] !== e) begin
      errors++;
      $display("FAIL partial_rx: got %h required %h", got_rx[0], e);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    clear_counts();
    for (int k = 0; k < 6; k++) mtx[k] = 8'(k + 1);
    for (int k = 0; k < 4; k++) exp_rx.push_back(8'(k + 1));
    spi_frame(0, 6, 0, 1'b0);
    checks++;
    if (rx_count[0] !== 5'd4 || ovf_cnt[0] != 2) begin
      errors++;
      $display("FAIL overflow_count: count=%0d ovf=%0d required 4 2",
               rx_count[0], ovf_cnt[0]);
    end
    drain(0, 4);
    for (int k = 0; k < 4; k++) begin
      e = exp_rx.pop_front();
      checks++;
      if (got_rx[k] !== e) begin
        errors++;
        $display("FAIL overflow_rx[%0d]: got %h required %h", k, got_rx[k], e);
      end
    end
    checks++;
    if (rx_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: rx_valid=%b required 0", rx_valid[0]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] e;
    clear_counts();
    mtx[0] = 8'h11;
    mtx[1] = 8'h22;
    exp_miso.push_back(8'hEE);
    exp_miso.push_back(8'hEE);
    spi_frame(0, 2, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      e = exp_miso.pop_front();
      checks++;
      if (mrx[k] !== e) begin
        errors++;
        $display("FAIL underrun_miso[%0d]: got %h required %h", k, mrx[k], e);
      end
    end
    checks++;
    if (unr_cnt[0] != 2) begin
      errors++;
      $display("FAIL underrun_pulses: got %0d required 2", unr_cnt[0]);
    end
    drain(0, 2);
  endtask

  task automatic test_tx_full();
    logic [7:0] e;
    for (int k = 0; k < 16; k++) tx_push(2, 8'(8'h40 + k));
    checks++;
    if (tx_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL tx_full: tx_ready=%b required 0", tx_ready[2]);
    end
    tx_push(2, 8'h99);
    mtx[0] = 8'h00;
    exp_miso.push_back(8'h40);
    spi_frame(2, 1, 0, 1'b0);
    e = exp_miso.pop_front();
    checks++;
    if (mrx[0] !== e || tx_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL tx_full_head: got %h ready=%b required %h 1",
               mrx[0], tx_ready[2], e);
    end
    drain(2, 1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    tx_push(0, 8'h33);
    tx_push(0, 8'h44);
    mtx[0] = 8'hFF;
    spi_frame(0, 1, 3, 1'b0);
    checks++;
    if (busy[0] !== 1'b1 || oe[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_word_busy: busy=%b oe=%b required 1 1",
               busy[0], oe[0]);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (status(0) !== 12'h100) begin
      errors++;
      $display("FAIL async_reset: got %h required 100", status(0));
    end
    wait_clk(1);
    cs[0] = 1'b1;
    mosi[0] = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    mtx[0] = 8'h5A;
    exp_rx.push_back(8'h5A);
    exp_miso.push_back(8'hEE);
    spi_frame(0, 1, 0, 1'b0);
    e = exp_miso.pop_front();
    checks++;
    if (mrx[0] !== e) begin
      errors++;
      $display("FAIL reset_flush_miso: got %h required %h", mrx[0], e);
    end
    checks++;
    if (rx_count[0] !== 5'd1) begin
      errors++;
      $display("FAIL reset_rx_count: got %0d required 1", rx_count[0]);
    end
    drain(0, 1);
    e = exp_rx.pop_front();
    checks++;
    if (got_rx[0] !== e) begin
      errors++;
      $display("FAIL reset_rx: got %h required %h", got_rx[0], e);
    end
  endtask

  initial begin
    wait_clk(3);
    test_reset();
    rst = 1'b0;
    wait_clk(3);
    test_reset();
    test_mode0();
    test_modes();
    test_partial();
    test_overflow();
    test_underrun();
    test_tx_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
- Parametrised SPI slave that replaces the SPI_CLK-domain receiver. All logic runs on the system clock; SCLK, CS and MOSI are synchronised and edge-detected.
- Supports all four SPI modes, a configurable word width, and full-duplex transfer.
- Received words go to an RX FIFO. Transmit words are drawn from a TX FIFO.
- Sits between the external MCU link and the dither pipeline's pixel/command loader.

Parameters:
- DATA_W, 8: bits per SPI word, MSB first; legal range 4-32.
- RX_DEPTH, 16: RX FIFO entries; power of two, at least 2.
- TX_DEPTH, 16: TX FIFO entries; power of two, at least 2.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- SYNC_STAGES, 2: synchroniser flops on spi_clk, spi_cs and spi_mosi; at least 2.
- TX_FILL, 0: word shifted out when the TX FIFO is empty.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- spi_clk, input, 1: SPI SCLK from the master.
- spi_cs, input, 1: chip select, active low.
- spi_mosi, input, 1: master-to-slave data.
- spi_miso, output, 1: slave-to-master data.
- spi_miso_oe, output, 1: MISO output enable; the top level tristates the pad when this is 0.
- rx_data, output, DATA_W: head of the RX FIFO (show-ahead).
- rx_valid, output, 1: RX FIFO is not empty.
- rx_ready, input, 1: pops the RX head when rx_valid is also high.
- tx_data, input, DATA_W: word to enqueue for transmit.
- tx_valid, input, 1: push request for the TX FIFO.
- tx_ready, output, 1: TX FIFO is not full.
- rx_count, output, clog2(RX_DEPTH)+1: current RX occupancy.
- busy, output, 1: synchronised CS is active.
- rx_overflow, output, 1: one-cycle pulse when a completed word is dropped.
- tx_underrun, output, 1: one-cycle pulse when TX_FILL is loaded because the TX FIFO was empty.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - Both FIFOs are emptied and the bit counter is cleared.
  - The FSM goes to IDLE.
  - spi_miso=0, spi_miso_oe=0, rx_valid=0, tx_ready=1, rx_count=0, busy=0, rx_overflow=0, tx_underrun=0.
  - Synchroniser flops reset to the idle values: spi_clk=CPOL, spi_cs=1.
- Clock ratio: clk must be at least 8x SCLK. Behaviour outside this ratio is undefined and is not checked.
- Edges are detected on the synchronised signal against its previous value.
  - Leading edge: SCLK transition from CPOL to !CPOL. Trailing edge: the opposite transition.
  - Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift edge: the other edge of the pair.
- FSM states:
  - IDLE: CS is high. spi_miso_oe=0, bit_cnt=0. A CS falling edge moves to LOAD.
  - LOAD (one clk cycle):
    - tx_shift is loaded from the TX FIFO head and the head is popped.
    - If the TX FIFO is empty, tx_shift is loaded with TX_FILL and tx_underrun pulses.
    - spi_miso is set to the tx_shift MSB and spi_miso_oe=1.
    - Next state is XFER.
  - XFER:
    - On each sample edge, rx_shift = {rx_shift[DATA_W-2:0], mosi_sync} and bit_cnt increments.
    - On each shift edge, tx_shift shifts left and spi_miso = the new MSB.
    - For CPHA=1, the first leading edge does not shift; the MSB is already driven.
    - When bit_cnt reaches DATA_W, the next state is PUSH.
  - PUSH (one clk cycle):
    - rx_shift is written to the RX FIFO and bit_cnt is cleared.
    - If the RX FIFO is full, the word is dropped, rx_overflow pulses, and the FIFO contents are unchanged.
    - Next state is LOAD, so the next word is preloaded before its first shift edge.
- CS rising edge in any state: go to IDLE.
  - A partial word (0 < bit_cnt < DATA_W) is discarded and never pushed.
  - A TX word already loaded is lost; it is not re-queued.
  - spi_miso_oe drops in the same cycle the rising edge is detected.
- Same-cycle conflicts:
  - A CS rise that coincides with completion of the final sample edge still pushes the completed word.
  - If bit_cnt=DATA_W and the CS rise are seen in the same cycle, PUSH takes priority; the FSM then goes to IDLE, not LOAD.
- FIFOs:
  - Synchronous, registered, show-ahead.
  - Push and pop in the same cycle on a full FIFO are both accepted.
  - Push and pop in the same cycle on an empty RX FIFO: the pop is ignored because rx_valid=0.
  - tx_valid while tx_ready=0 is ignored with no side effect.
  - Pointers wrap modulo depth; an extra pointer bit distinguishes full from empty.
- Latency: rx_valid rises no more than SYNC_STAGES+4 clk cycles after the raw SCLK edge that samples the final bit.
- busy equals the inverse of the synchronised CS.

Test Plan:
- Mode 0, DATA_W=8: master sends 0xA5, 0x3C with the TX FIFO preloaded with 0x81, 0x7E -> rx_data pops 0xA5 then 0x3C; master receives 0x81 then 0x7E; no pulses.
- Mode sweep (CPOL/CPHA = 01, 10, 11): full-duplex transfer of 0xC3 -> rx=0xC3 and MISO=0xC3 in every mode; the MISO bit is stable on every master sample edge.
- CS raised after 5 bits of 0xFF, then a full 0x12 -> only 0x12 is received; rx_count=1; no overflow pulse.
- RX_DEPTH=4 with rx_ready=0, master sends 6 words 0x01..0x06 -> rx_count=4; 0x01..0x04 are retained; exactly 2 rx_overflow pulses.
- TX FIFO empty, TX_FILL=0xEE, master clocks 2 words -> MISO returns 0xEE, 0xEE; 2 tx_underrun pulses.
- rst asserted mid-word after 3 bits -> all outputs reach their reset values asynchronously; a following 0x5A transfer is received cleanly as 0x5A.
